// File: rtl/sram_model_pkg.sv
// rtl/sram_model_pkg.sv - shared widths, byte constant and op encoding for the 1RW1R SRAM model
package sram_model_pkg;

   localparam int BYTE_WIDTH     = 8;
   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_ADDR_WIDTH = 10;

   typedef enum logic [1:0] {
      OP_IDLE  = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2
   } op_e;

   function automatic op_e decode_op(input logic csb, input logic web);
      if (csb) begin
         return OP_IDLE;
      end else if (web) begin
         return OP_READ;
      end else begin
         return OP_WRITE;
      end
   endfunction

endpackage

// File: rtl/sram_port_capture.sv
// rtl/sram_port_capture.sv - rising-edge input registers for one SRAM port
// Reset cancels the captured op so the following falling edge does nothing.
module sram_port_capture
   import sram_model_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_WMASKS = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_csb,
   input  logic                  i_web,
   input  logic [NUM_WMASKS-1:0] i_wmask,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_din,
   output op_e                   o_op,
   output logic [NUM_WMASKS-1:0] o_wmask,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [DATA_WIDTH-1:0] o_din,
   output logic                  o_rst
);

   op_e                   r_op;
   logic [NUM_WMASKS-1:0] r_wmask;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_din;
   logic                  r_rst;

   always_ff @(posedge i_clk) begin
      r_rst   <= i_rst;
      r_wmask <= i_wmask;
      r_addr  <= i_addr;
      r_din   <= i_din;
      if (i_rst) begin
         r_op <= OP_IDLE;
      end else begin
         r_op <= decode_op(i_csb, i_web);
      end
   end

   assign o_op    = r_op;
   assign o_wmask = r_wmask;
   assign o_addr  = r_addr;
   assign o_din   = r_din;
   assign o_rst   = r_rst;

endmodule

// File: rtl/sram_1rw1r_model.sv
// rtl/sram_1rw1r_model.sv - 1RW + 1R SRAM model, capture on rise, access on fall
// Optional macro SRAM_WMASK_EN enables per-byte write masking on port 0.
module sram_1rw1r_model
   import sram_model_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_WMASKS = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clk0,
   input  logic                  rst0,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [NUM_WMASKS-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0,
   output logic                  valid0,
   input  logic                  csb1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [DATA_WIDTH-1:0] dout1,
   output logic                  valid1,
   output logic                  collision
);

   localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;

   op_e                   w_op0;
   op_e                   w_op1;
   logic [NUM_WMASKS-1:0] w_wmask0;
   logic [NUM_WMASKS-1:0] w_wmask1;
   logic [ADDR_WIDTH-1:0] w_addr0;
   logic [ADDR_WIDTH-1:0] w_addr1;
   logic [DATA_WIDTH-1:0] w_din0;
   logic [DATA_WIDTH-1:0] w_din1;
   logic                  w_rst_q;
   logic                  w_rst1;
   logic [NUM_WMASKS-1:0] w_eff_mask;
   logic                  w_collide;
   logic                  w_unused;

   logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
   logic [DATA_WIDTH-1:0] r_data0;
   logic [DATA_WIDTH-1:0] r_data1;
   logic                  r_vld0;
   logic                  r_vld1;
   logic                  r_col;
   logic                  r_cyc;
   logic                  r_neg_cyc;

   sram_port_capture #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_WMASKS(NUM_WMASKS)
   ) u_cap0 (
      .i_clk  (clk0),
      .i_rst  (rst0),
      .i_csb  (csb0),
      .i_web  (web0),
      .i_wmask(wmask0),
      .i_addr (addr0),
      .i_din  (din0),
      .o_op   (w_op0),
      .o_wmask(w_wmask0),
      .o_addr (w_addr0),
      .o_din  (w_din0),
      .o_rst  (w_rst_q)
   );

   sram_port_capture #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_WMASKS(NUM_WMASKS)
   ) u_cap1 (
      .i_clk  (clk0),
      .i_rst  (rst0),
      .i_csb  (csb1),
      .i_web  (1'b1),
      .i_wmask({NUM_WMASKS{1'b0}}),
      .i_addr (addr1),
      .i_din  ({DATA_WIDTH{1'b0}}),
      .o_op   (w_op1),
      .o_wmask(w_wmask1),
      .o_addr (w_addr1),
      .o_din  (w_din1),
      .o_rst  (w_rst1)
   );

`ifdef SRAM_WMASK_EN
   assign w_eff_mask = w_wmask0;
   assign w_unused   = ^{w_wmask1, w_din1, w_rst1};
`else
   assign w_eff_mask = {NUM_WMASKS{1'b1}};
   assign w_unused   = ^{w_wmask1, w_din1, w_rst1, w_wmask0};
`endif

   // An all-zero mask leaves memory untouched, so it is not a collision.
   assign w_collide = (w_op0 == OP_WRITE) && (w_op1 == OP_READ) &&
                      (w_addr0 == w_addr1) && (|w_eff_mask);

   // Cycle parity lets falling-edge flags expire at the next rising edge.
   always_ff @(posedge clk0) begin
      if (rst0) begin
         r_cyc <= 1'b0;
      end else begin
         r_cyc <= ~r_cyc;
      end
   end

   always_ff @(negedge clk0) begin
      r_neg_cyc <= r_cyc;
      r_col     <= w_collide;
      if (w_op0 == OP_WRITE) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (w_eff_mask[i]) begin
               r_mem[w_addr0][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_din0[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
      if (w_op0 == OP_READ) begin
         r_data0 <= r_mem[w_addr0];
         r_vld0  <= 1'b1;
      end else begin
         r_vld0 <= 1'b0;
         if (w_rst_q) begin
            r_data0 <= '0;
         end
      end
      if (w_op1 == OP_READ) begin
         r_data1 <= r_mem[w_addr1];
         r_vld1  <= 1'b1;
      end else begin
         r_vld1 <= 1'b0;
         if (w_rst_q) begin
            r_data1 <= '0;
         end
      end
   end

   assign dout0     = w_rst_q ? '0 : r_data0;
   assign dout1     = w_rst_q ? '0 : r_data1;
   assign valid0    = r_vld0 & ~w_rst_q & (r_neg_cyc == r_cyc);
   assign valid1    = r_vld1 & ~w_rst_q & (r_neg_cyc == r_cyc);
   assign collision = r_col  & ~w_rst_q & (r_neg_cyc == r_cyc);

endmodule

// File: tb/tb_sram_1rw1r_model.sv
// tb/tb_sram_1rw1r_model.sv - directed bench with a behavioural memory model for sram_1rw1r_model
module tb_sram_1rw1r_model;

   logic        clk0 = 1'b0;
   logic        rst0;
   logic        csb0;
   logic        web0;
   logic [7:0]  wmask0;
   logic [9:0]  addr0;
   logic [63:0] din0;
   logic [63:0] dout0;
   logic        valid0;
   logic        csb1;
   logic [9:0]  addr1;
   logic [63:0] dout1;
   logic        valid1;
   logic        collision;

   int total = 0;
   int bad   = 0;

   logic [63:0] mm [0:1023];
   logic [63:0] m_dout0 = '0;
   logic [63:0] m_dout1 = '0;

   logic        c_rst, c_csb0, c_web0, c_csb1;
   logic [7:0]  c_wmask;
   logic [9:0]  c_addr0, c_addr1;
   logic [63:0] c_din;

   sram_1rw1r_model dut (
      .clk0     (clk0),
      .rst0     (rst0),
      .csb0     (csb0),
      .web0     (web0),
      .wmask0   (wmask0),
      .addr0    (addr0),
      .din0     (din0),
      .dout0    (dout0),
      .valid0   (valid0),
      .csb1     (csb1),
      .addr1    (addr1),
      .dout1    (dout1),
      .valid1   (valid1),
      .collision(collision)
   );

   initial forever #5 clk0 = ~clk0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Behavioural model: a word array, byte-lane writes, reads see pre-write contents.
   always begin : cmp
      logic [7:0] em;
      logic       wr, rd0, rd1, ecol;
      @(posedge clk0);
      c_rst = rst0; c_csb0 = csb0; c_web0 = web0; c_csb1 = csb1;
      c_wmask = wmask0; c_addr0 = addr0; c_addr1 = addr1; c_din = din0;
      #1;
      if (c_rst) begin
         m_dout0 = '0;
         m_dout1 = '0;
      end
      chk("rise_valid0", valid0, 1'b0);
      chk("rise_valid1", valid1, 1'b0);
      chk("rise_collision", collision, 1'b0);
      chk("rise_dout0", dout0, m_dout0);
      chk("rise_dout1", dout1, m_dout1);
      @(negedge clk0);
      #1;
`ifdef SRAM_WMASK_EN
      em = c_wmask;
`else
      em = 8'hFF;
`endif
      wr   = !c_rst && !c_csb0 && !c_web0;
      rd0  = !c_rst && !c_csb0 &&  c_web0;
      rd1  = !c_rst && !c_csb1;
      ecol = wr && rd1 && (c_addr0 == c_addr1) && (em != 8'h00);
      if (rd0) m_dout0 = mm[c_addr0];
      if (rd1) m_dout1 = mm[c_addr1];
      if (wr) begin
         for (int b = 0; b < 8; b++) begin
            if (em[b]) mm[c_addr0][8*b +: 8] = c_din[8*b +: 8];
         end
      end
      chk("fall_valid0", valid0, rd0);
      chk("fall_valid1", valid1, rd1);
      chk("fall_collision", collision, ecol);
      chk("fall_dout0", dout0, m_dout0);
      chk("fall_dout1", dout1, m_dout1);
   end

   task automatic do_op(input logic r, input logic c0, input logic w0, input logic [9:0] a0,
                        input logic [63:0] d, input logic [7:0] m, input logic c1, input logic [9:0] a1);
      rst0 = r; csb0 = c0; web0 = w0; addr0 = a0; din0 = d; wmask0 = m; csb1 = c1; addr1 = a1;
      @(negedge clk0);
      #2;
   endtask

   task automatic wr(input logic [9:0] a, input logic [63:0] d, input logic [7:0] m);
      do_op(1'b0, 1'b0, 1'b0, a, d, m, 1'b1, 10'd0);
   endtask

   task automatic rd(input logic [9:0] a);
      do_op(1'b0, 1'b0, 1'b1, a, 64'd0, 8'd0, 1'b1, 10'd0);
   endtask

   task automatic idle();
      do_op(1'b0, 1'b1, 1'b1, 10'd0, 64'd0, 8'd0, 1'b1, 10'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] exp1;
      rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; addr0 = '0; din0 = '0; wmask0 = '0;
      csb1 = 1'b1; addr1 = '0;
      @(negedge clk0);
      #2;
      do_op(1'b1, 1'b1, 1'b1, 10'd0, 64'd0, 8'd0, 1'b1, 10'd0);
      chk("reset_dout0", dout0, 64'd0);
      chk("reset_valid0", valid0, 1'b0);

      // Write presented during reset is cancelled
      wr(10'h001, 64'h1111, 8'hFF);
      do_op(1'b1, 1'b0, 1'b0, 10'h001, 64'hDEAD, 8'hFF, 1'b1, 10'd0);
      chk("rst_wr_dout0", dout0, 64'd0);
      chk("rst_wr_valid0", valid0, 1'b0);
      rd(10'h001);
      chk("rst_wr_mem", dout0, 64'h1111);

      wr(10'h005, 64'h1122334455667788, 8'hFF);
      rd(10'h005);
      chk("basic_dout0", dout0, 64'h1122334455667788);
      chk("basic_valid0", valid0, 1'b1);

      wr(10'h010, 64'd0, 8'hFF);
      wr(10'h010, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
      rd(10'h010);
`ifdef SRAM_WMASK_EN
      chk("mask_dout0", dout0, 64'h00000000FFFFFFFF);
`else
      chk("mask_dout0", dout0, 64'hFFFFFFFFFFFFFFFF);
`endif

      wr(10'h3FF, 64'hA, 8'hFF);
      do_op(1'b0, 1'b0, 1'b0, 10'h3FF, 64'hB, 8'hFF, 1'b0, 10'h3FF);
      chk("col_dout1", dout1, 64'hA);
      chk("col_flag", collision, 1'b1);
      rd(10'h3FF);
      chk("col_after", dout0, 64'hB);
      idle();
      chk("hold_dout1", dout1, 64'hA);

      do_op(1'b0, 1'b0, 1'b0, 10'h005, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0, 10'h005);
      chk("zmask_dout1", dout1, 64'h1122334455667788);
      rd(10'h005);
`ifdef SRAM_WMASK_EN
      chk("zmask_mem", dout0, 64'h1122334455667788);
`else
      chk("zmask_mem", dout0, 64'hFFFFFFFFFFFFFFFF);
`endif

      for (int i = 0; i < 8; i++) wr(10'(i), 64'h100 + 64'(i), 8'hFF);
      for (int i = 0; i < 8; i++) begin
         do_op(1'b0, 1'b0, 1'b0, 10'(i), 64'hC0DE0000 + 64'(i), 8'hFF, 1'b0, 10'(7 - i));
         do_op(1'b0, 1'b0, 1'b1, 10'(i), 64'd0, 8'd0, 1'b0, 10'(7 - i));
         exp1 = (7 - i < i) ? 64'hC0DE0000 + 64'(7 - i) : 64'h100 + 64'(7 - i);
         chk("b2b_dout0", dout0, 64'hC0DE0000 + 64'(i));
         chk("b2b_dout1", dout1, exp1);
      end
      idle();
      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
